// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult_seq
//  Description : Iterative radix-2 Booth multiplier. One recoded multiplier
//                bit is retired per clock. Signed or unsigned operands are
//                selected per operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // Counter must reach WIDTH (last iteration index) and WIDTH+1 after it.
    localparam int                c_cnt_w     = $clog2(WIDTH + 2);
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH:0]       r_mcand;     // extended multiplicand
    logic [2*WIDTH+1:0]   r_acc;       // {A, Q}: upper half accumulator, lower half multiplier
    logic                 r_qm1;       // Q(-1)
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH:0]       w_upper;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH+1:0]   w_acc_shift;
    logic                 w_last;

    assign w_last  = (r_cnt == c_last_iter);
    assign ready   = (r_state == S_IDLE);
    assign done    = r_done;
    assign product = r_product;

    // One Booth step: add/subtract on {Q0,Q(-1)}, then arithmetic shift right.
    always_comb begin
        w_upper = r_acc[2*WIDTH+1:WIDTH+1];
        w_sum   = w_upper;
        case ({r_acc[0], r_qm1})
            2'b01:   w_sum = w_upper + r_mcand;
            2'b10:   w_sum = w_upper - r_mcand;
            default: w_sum = w_upper;
        endcase
        w_acc_shift = {w_sum[WIDTH], w_sum, r_acc[WIDTH:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, iterate WIDTH+1 times, one DONE cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_CALC;
            S_CALC:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, Booth iterations and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_qm1     <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand <= {signed_mode & a[WIDTH-1], a};
                        r_acc   <= {{(WIDTH+1){1'b0}}, signed_mode & b[WIDTH-1], b};
                        r_qm1   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_shift;
                    r_qm1 <= r_acc[0];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_done    <= 1'b1;
                        r_product <= w_acc_shift[2*WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_mult_seq
//  Description : Self-checking bench for booth_mult_seq at WIDTH 8, 16, 32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic        sm;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic [2:0]  rdy;
    logic [2:0]  dn;
    logic [15:0] p8;
    logic [31:0] p16;
    logic [63:0] p32;

    int checks;
    int errors;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(sm),
        .a(a_in[7:0]), .b(b_in[7:0]), .ready(rdy[0]), .done(dn[0]), .product(p8)
    );
    booth_mult_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(sm),
        .a(a_in[15:0]), .b(b_in[15:0]), .ready(rdy[1]), .done(dn[1]), .product(p16)
    );
    booth_mult_seq #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(sm),
        .a(a_in[31:0]), .b(b_in[31:0]), .ready(rdy[2]), .done(dn[2]), .product(p32)
    );

    typedef struct {
        int          idx;
        logic [63:0] a;
        logic [63:0] b;
        bit          s;
        logic [63:0] exp;
    } vec_t;

    function automatic int wof(int idx);
        return (idx == 0) ? 8 : (idx == 1) ? 16 : 32;
    endfunction

    function automatic logic [63:0] prod_of(int idx);
        if (idx == 0) return 64'(p8);
        if (idx == 1) return 64'(p16);
        return p32;
    endfunction

    // Exact product of the w-bit operands, reduced to 2w bits.
    function automatic logic [63:0] model(int w, logic [63:0] x, logic [63:0] y, bit s);
        logic [127:0] m, pm, ex, ey, p;
        m  = (128'd1 << w) - 128'd1;
        pm = (128'd1 << (2 * w)) - 128'd1;
        ex = {64'd0, x} & m;
        ey = {64'd0, y} & m;
        if (s && ex[w-1]) ex = ex | ~m;
        if (s && ey[w-1]) ey = ey | ~m;
        p = (ex * ey) & pm;
        return p[63:0];
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(int idx, string name);
        int n;
        n = 0;
        while (!rdy[idx] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " ready"}, 64'(rdy[idx]), 64'd1);
    endtask

    // One full operation; inputs are scrambled right after acceptance.
    task automatic do_op(int idx, logic [63:0] x, logic [63:0] y, bit s,
                         logic [63:0] exp, string name);
        int          w, n;
        logic [63:0] prev;
        bit          held_bad;
        w = wof(idx);
        wait_ready(idx, name);
        prev = prod_of(idx);
        held_bad = 1'b0;
        a_in = x; b_in = y; sm = s; start_v[idx] = 1'b1;
        @(posedge clk); #1;                      // acceptance edge k
        start_v[idx] = 1'b0;
        a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom}; sm = ~s;
        chk({name, " busy"}, 64'(rdy[idx]), 64'd0);
        n = 0;
        while (!dn[idx] && n < w + 10) begin
            if (prod_of(idx) !== prev) held_bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        // done is visible just after edge k+WIDTH+1, i.e. sampled high at edge k+WIDTH+2
        chk({name, " latency"}, 64'(n), 64'(w + 1));
        chk({name, " product"}, prod_of(idx), exp);
        chk({name, " held"}, 64'(held_bad), 64'd0);
        @(posedge clk); #1;
        chk({name, " pulse"}, 64'(dn[idx]), 64'd0);
        chk({name, " hold"}, prod_of(idx), exp);
        chk({name, " idle"}, 64'(rdy[idx]), 64'd1);
    endtask

    vec_t        tbl [12];
    logic [63:0] exp_q [$];

    initial begin
        int          pulses, first_n, ndone, last, cyc, w;
        logic [63:0] cap, x, y;
        bit          s;

        checks = 0; errors = 0;
        start_v = '0; a_in = '0; b_in = '0; sm = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset ready%0d", i), 64'(rdy[i]), 64'd1);
            chk($sformatf("reset done%0d", i), 64'(dn[i]), 64'd0);
            chk($sformatf("reset product%0d", i), prod_of(i), 64'd0);
        end
        rst_n = 1'b1;

        tbl[0]  = '{2, 64'hFFFFFFF9, 64'h3,        1'b1, 64'hFFFFFFFFFFFFFFEB};
        tbl[1]  = '{2, 64'h80000000, 64'h80000000, 1'b1, 64'h4000000000000000};
        tbl[2]  = '{2, 64'h80000000, 64'h7FFFFFFF, 1'b1, 64'hC000000080000000};
        tbl[3]  = '{2, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
        tbl[4]  = '{2, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 64'h1};
        tbl[5]  = '{0, 64'h7F,       64'h81,       1'b1, 64'hC0FF};
        tbl[6]  = '{0, 64'h80,       64'h80,       1'b0, 64'h4000};
        tbl[7]  = '{0, 64'h80,       64'h80,       1'b1, 64'h4000};
        tbl[8]  = '{0, 64'hFF,       64'h01,       1'b1, 64'hFFFF};
        tbl[9]  = '{1, 64'hFFFF,     64'hFFFF,     1'b0, 64'hFFFE0001};
        tbl[10] = '{1, 64'h8000,     64'h7FFF,     1'b1, 64'hC0008000};
        tbl[11] = '{2, 64'h0,        64'h12345678, 1'b1, 64'h0};
        for (int i = 0; i < 12; i++)
            do_op(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, $sformatf("vec%0d", i));

        // Random operations against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            w = wof(i % 3);
            x = {$urandom, $urandom}; y = {$urandom, $urandom}; s = 1'($urandom);
            do_op(i % 3, x, y, s, model(w, x, y, s), $sformatf("rnd%0d", i));
        end

        // Second start in the middle of CALC must be ignored.
        wait_ready(0, "ign");
        a_in = 64'h05; b_in = 64'hFD; sm = 1'b1; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a_in = 64'h11; b_in = 64'h22; sm = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        pulses = 0; first_n = 0; cap = '0;
        for (int n = 4; n <= 30; n++) begin
            @(posedge clk); #1;
            if (dn[0]) begin
                pulses++;
                if (pulses == 1) begin
                    first_n = n;
                    cap = 64'(p8);
                end
            end
        end
        chk("ign pulses", 64'(pulses), 64'd1);
        chk("ign latency", 64'(first_n), 64'd9);
        chk("ign product", cap, 64'hFFF1);

        // Asynchronous reset in the middle of CALC aborts the operation.
        wait_ready(0, "rst");
        a_in = 64'h03; b_in = 64'h04; sm = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst ready", 64'(rdy[0]), 64'd1);
        chk("rst done", 64'(dn[0]), 64'd0);
        chk("rst product", 64'(p8), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (dn[0]) pulses++;
        end
        chk("rst no done", 64'(pulses), 64'd0);
        do_op(0, 64'h7F, 64'h81, 1'b1, 64'hC0FF, "post rst");

        // start held high: back-to-back operations on the 16-bit instance.
        wait_ready(1, "b2b");
        x = {$urandom, $urandom}; y = {$urandom, $urandom}; s = 1'($urandom);
        a_in = x; b_in = y; sm = s;
        exp_q.push_back(model(16, x, y, s));
        start_v[1] = 1'b1;
        ndone = 0; last = -1; cyc = 0;
        while (ndone < 20 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (dn[1]) begin
                if (exp_q.size() > 0) chk($sformatf("b2b product%0d", ndone), 64'(p16), exp_q.pop_front());
                else chk($sformatf("b2b extra%0d", ndone), 64'(ndone), 64'd99);
                if (last >= 0) chk($sformatf("b2b spacing%0d", ndone), 64'(cyc - last), 64'd19);
                last = cyc;
                ndone++;
            end
            if (rdy[1]) begin
                x = {$urandom, $urandom}; y = {$urandom, $urandom}; s = 1'($urandom);
                a_in = x; b_in = y; sm = s;
                exp_q.push_back(model(16, x, y, s));
            end
        end
        start_v[1] = 1'b0;
        chk("b2b count", 64'(ndone), 64'd20);
        repeat (3) @(posedge clk);
        #1;
        wait_ready(1, "b2b end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
